// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C EEPROM-style target.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    WADDR,
    WADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    IGNORE
  } i2c_slv_state_e;

  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with a history flop; derives edge and START/STOP events.
`timescale 1ns/1ps
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic areset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_p0;
  logic [SYNC_STAGES-1:0] sda_p0;
  logic                   scl_p1;
  logic                   sda_p1;

  // Stage p0: metastability chain; stage p1: one-cycle history for edge detection
  always_ff @(posedge aclk) begin
    if (areset) begin
      scl_p0 <= '1;
      sda_p0 <= '1;
      scl_p1 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= {scl_p0[SYNC_STAGES-2:0], scl_i};
      sda_p0 <= {sda_p0[SYNC_STAGES-2:0], sda_i};
      scl_p1 <= scl_p0[SYNC_STAGES-1];
      sda_p1 <= sda_p0[SYNC_STAGES-1];
    end
  end

  assign scl       = scl_p0[SYNC_STAGES-1];
  assign sda       = sda_p0[SYNC_STAGES-1];
  assign scl_rise  =  scl & ~scl_p1;
  assign scl_fall  = ~scl &  scl_p1;
  // SDA may only move while SCL is high for a START/STOP, so both SCL samples must be high
  assign start_det = scl & scl_p1 &  sda_p1 & ~sda;
  assign stop_det  = scl & scl_p1 & ~sda_p1 &  sda;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C target with 24C02-style byte-addressed storage, page-wrapped writes and
// sequential reads. Only ever pulls SDA low; never touches SCL.
`timescale 1ns/1ps
module i2c_eeprom_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         MEM_DEPTH   = 256,
  parameter int         PAGE_SIZE   = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic [7:0] ptr,
  output logic       wr_pulse
);

  localparam int         ADDR_W    = $clog2(MEM_DEPTH);
  localparam logic [7:0] PTR_MASK  = 8'(MEM_DEPTH - 1);
  localparam logic [7:0] PAGE_MASK = 8'(PAGE_SIZE - 1);

  function automatic logic [7:0] ptr_inc(input logic [7:0] p);
    return (p + 8'd1) & PTR_MASK;
  endfunction

  // Writes stay inside the current page: only the low bits advance and wrap
  function automatic logic [7:0] page_inc(input logic [7:0] p);
    return (p & ~PAGE_MASK) | ((p + 8'd1) & PAGE_MASK);
  endfunction

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .aclk     (aclk),
    .areset   (areset),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  logic [7:0] mem [MEM_DEPTH] = '{default: 8'hFF};

  i2c_slv_state_e state, state_nxt;
  logic [2:0]     bit_cnt, bit_cnt_nxt;
  logic [6:0]     shreg, shreg_nxt;
  logic [7:0]     tx, tx_nxt;
  logic [7:0]     ptr_nxt;
  logic           rw_q, rw_nxt;
  logic           sda_drv_p0, sda_drv_nxt;
  logic           busy_nxt, wr_nxt, mem_we;
  logic           bit_rise, bit_fall;
  logic [7:0]     rx_byte, rd_byte;
  logic [ADDR_W-1:0] ptr_idx;

  // Edge events qualified by the settled level they lead to
  assign bit_rise = scl_rise &  scl;
  assign bit_fall = scl_fall & ~scl;
  assign rx_byte  = {shreg, sda};
  assign ptr_idx  = ptr[ADDR_W-1:0];
  assign rd_byte  = mem[ptr_idx];

  // Control registers; sda_oe trails the drive decision by one cycle
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      tx         <= 8'd0;
      ptr        <= 8'd0;
      rw_q       <= 1'b0;
      sda_drv_p0 <= 1'b0;
      busy       <= 1'b0;
      wr_pulse   <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      tx         <= tx_nxt;
      ptr        <= ptr_nxt;
      rw_q       <= rw_nxt;
      sda_drv_p0 <= sda_drv_nxt;
      busy       <= busy_nxt;
      wr_pulse   <= wr_nxt;
      sda_oe     <= (start_det | stop_det) ? 1'b0 : sda_drv_p0;
    end
  end

  // Storage write port; contents survive reset
  always_ff @(posedge aclk) begin
    if (mem_we && !areset) mem[ptr_idx] <= rx_byte;
  end

  // Next-state logic: bus conditions first, then per-state bit handling
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    tx_nxt      = tx;
    ptr_nxt     = ptr;
    rw_nxt      = rw_q;
    sda_drv_nxt = sda_drv_p0;
    busy_nxt    = busy;
    wr_nxt      = 1'b0;
    mem_we      = 1'b0;

    if (start_det) begin
      state_nxt   = DEV;
      bit_cnt_nxt = 3'd0;
      shreg_nxt   = 7'd0;
      sda_drv_nxt = 1'b0;
      busy_nxt    = 1'b0;
    end else if (stop_det) begin
      state_nxt   = IDLE;
      sda_drv_nxt = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      unique case (state)
        DEV: begin
          if (bit_rise) begin
            shreg_nxt   = {shreg[5:0], sda};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_nxt = DEV_ACK;
                busy_nxt  = 1'b1;
                rw_nxt    = rx_byte[0];
              end else begin
                state_nxt = IGNORE;
              end
            end
          end
        end
        // ACK phases: first fall pulls SDA, second fall releases and moves on
        DEV_ACK, WADDR_ACK, WDATA_ACK: begin
          if (bit_fall) begin
            if (!sda_drv_p0) begin
              sda_drv_nxt = ~ACK;
            end else begin
              sda_drv_nxt = 1'b0;
              bit_cnt_nxt = 3'd0;
              shreg_nxt   = 7'd0;
              if (state == DEV_ACK) begin
                unique case (rw_q)
                  I2C_RW_READ: begin
                    state_nxt   = RDATA;
                    tx_nxt      = rd_byte;
                    sda_drv_nxt = ~rd_byte[7];
                  end
                  I2C_RW_WRITE: state_nxt = WADDR;
                endcase
              end else begin
                state_nxt = WDATA;
              end
            end
          end
        end
        WADDR: begin
          if (bit_rise) begin
            shreg_nxt   = {shreg[5:0], sda};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr_nxt   = rx_byte & PTR_MASK;
              state_nxt = WADDR_ACK;
            end
          end
        end
        WDATA: begin
          if (bit_rise) begin
            shreg_nxt   = {shreg[5:0], sda};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              mem_we    = 1'b1;
              wr_nxt    = 1'b1;
              ptr_nxt   = page_inc(ptr);
              state_nxt = WDATA_ACK;
            end
          end
        end
        RDATA: begin
          if (bit_fall) begin
            sda_drv_nxt = ~tx[7];
          end else if (bit_rise) begin
            tx_nxt      = {tx[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr_nxt   = ptr_inc(ptr);
              state_nxt = RACK;
            end
          end
        end
        RACK: begin
          if (bit_fall) begin
            sda_drv_nxt = 1'b0;
          end else if (bit_rise) begin
            unique case (sda)
              ACK: begin
                state_nxt   = RDATA;
                tx_nxt      = rd_byte;
                bit_cnt_nxt = 3'd0;
              end
              NACK: state_nxt = IGNORE;
            endcase
          end
        end
        IGNORE: sda_drv_nxt = 1'b0;
        IDLE:   sda_drv_nxt = 1'b0;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master on a wired-AND SDA line.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;

  localparam int Q = 100;  // quarter SCL period in ns

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic       sda_line;
  logic       sda_oe, busy, wr_pulse;
  logic [7:0] ptr;

  int n_vec  = 0;
  int n_miss = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] ptr_after;
  } vec_t;
  vec_t tbl[6];

  logic [7:0] wq[$];
  logic [7:0] rq[$];

  always #5 clk = ~clk;

  assign sda_line = ~(m_sda_low | sda_oe);

  i2c_eeprom_slave dut (
    .aclk    (clk),
    .areset  (rst),
    .scl_i   (m_scl),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .ptr     (ptr),
    .wr_pulse(wr_pulse)
  );

  always @(negedge clk) begin
    if (wr_pulse) wr_cnt++;
    if (sda_oe) oe_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [7:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL sb_empty: got %0h, want nothing", act);
    end else begin
      e = sb.pop_front();
      chk(e.tag, 32'(act), 32'(e.val));
    end
  endtask

  task automatic bit_out(input logic b);
    #Q m_sda_low = ~b;
    #Q m_scl = 1'b1;
    #(2*Q) m_scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    #Q m_sda_low = 1'b0;
    #Q m_scl = 1'b1;
    #Q b = sda_line;
    #Q m_scl = 1'b0;
  endtask

  task automatic start_cond;
    #Q m_sda_low = 1'b0;
    #Q m_scl = 1'b1;
    #Q m_sda_low = 1'b1;
    #Q m_scl = 1'b0;
  endtask

  task automatic stop_cond;
    #Q m_sda_low = 1'b1;
    #Q m_scl = 1'b1;
    #Q m_sda_low = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic a;
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(a);
    sb_pop({7'b0, a});
  endtask

  task automatic recv_byte(input logic nack);
    logic [7:0] d;
    logic       b;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(nack);
    sb_pop(d);
  endtask

  task automatic write_seq(input logic [7:0] waddr);
    start_cond;
    sb_push("dev_w_ack", 8'h00);
    send_byte(8'hA0);
    sb_push("waddr_ack", 8'h00);
    send_byte(waddr);
    foreach (wq[i]) begin
      sb_push($sformatf("wdata_ack[%0d]", i), 8'h00);
      send_byte(wq[i]);
    end
    chk("busy_in_write", 32'(busy), 32'd1);
    stop_cond;
    chk("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic read_seq(input logic [7:0] raddr);
    start_cond;
    sb_push("dev_w_ack", 8'h00);
    send_byte(8'hA0);
    sb_push("raddr_ack", 8'h00);
    send_byte(raddr);
    start_cond;
    sb_push("dev_r_ack", 8'h00);
    send_byte(8'hA1);
    foreach (rq[i]) begin
      sb_push($sformatf("rdata@%0h[%0d]", raddr, i), rq[i]);
      recv_byte(i == rq.size() - 1);
    end
    #Q;
    chk("oe_released_after_nack", 32'(sda_oe), 32'd0);
    stop_cond;
  endtask

  initial begin
    int  w0, o0;
    logic b;

    tbl[0] = '{addr: 8'h1E, data: 8'h11, ptr_after: 8'h1F};
    tbl[1] = '{addr: 8'h1F, data: 8'h22, ptr_after: 8'h20};
    tbl[2] = '{addr: 8'h10, data: 8'h33, ptr_after: 8'h11};
    tbl[3] = '{addr: 8'h11, data: 8'h5A, ptr_after: 8'h12};
    tbl[4] = '{addr: 8'h20, data: 8'hFF, ptr_after: 8'h21};
    tbl[5] = '{addr: 8'h12, data: 8'hFF, ptr_after: 8'h13};

    // reset state
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ptr", 32'(ptr), 32'd0);
    chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // two-byte write at 0x10
    w0 = wr_cnt;
    wq = '{8'hA5, 8'h5A};
    write_seq(8'h10);
    chk("wr_pulses_2", 32'(wr_cnt - w0), 32'd2);
    chk("ptr_after_write", 32'(ptr), 32'h12);

    // random read back with repeated START
    rq = '{8'hA5, 8'h5A};
    read_seq(8'h10);
    chk("ptr_after_read", 32'(ptr), 32'h12);

    // page wrap
    w0 = wr_cnt;
    wq = '{8'h11, 8'h22, 8'h33};
    write_seq(8'h1E);
    chk("wr_pulses_3", 32'(wr_cnt - w0), 32'd3);
    chk("ptr_page_wrap", 32'(ptr), 32'h11);

    // address mismatch: nothing acknowledged, nothing written
    w0 = wr_cnt;
    o0 = oe_cnt;
    start_cond;
    sb_push("mismatch_dev_nack", 8'h01);
    send_byte(8'hA2);
    sb_push("mismatch_b0_nack", 8'h01);
    send_byte(8'h10);
    sb_push("mismatch_b1_nack", 8'h01);
    send_byte(8'h77);
    chk("mismatch_busy", 32'(busy), 32'd0);
    stop_cond;
    chk("mismatch_oe_cycles", 32'(oe_cnt - o0), 32'd0);
    chk("mismatch_wr_pulses", 32'(wr_cnt - w0), 32'd0);

    // single-byte read-back table
    for (int k = 0; k < 6; k++) begin
      rq = '{tbl[k].data};
      read_seq(tbl[k].addr);
      chk($sformatf("tbl%0d_ptr", k), 32'(ptr), 32'(tbl[k].ptr_after));
    end

    // read wrap across the top of memory
    wq = '{8'hC3};
    write_seq(8'hFF);
    chk("ptr_ff_page_wrap", 32'(ptr), 32'hF0);
    wq = '{8'h3C};
    write_seq(8'h00);
    rq = '{8'hC3, 8'h3C};
    read_seq(8'hFF);
    chk("ptr_read_wrap", 32'(ptr), 32'h01);

    // reset mid-byte while the target drives SDA
    start_cond;
    sb_push("rst_dev_w_ack", 8'h00);
    send_byte(8'hA0);
    sb_push("rst_waddr_ack", 8'h00);
    send_byte(8'h10);
    start_cond;
    sb_push("rst_dev_r_ack", 8'h00);
    send_byte(8'hA1);
    bit_in(b);
    chk("rst_rd_bit7", 32'(b), 32'd0);
    #Q;
    chk("oe_before_rst", 32'(sda_oe), 32'd1);
    chk("ptr_before_rst", 32'(ptr), 32'h10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("oe_after_rst", 32'(sda_oe), 32'd0);
    chk("busy_after_rst", 32'(busy), 32'd0);
    chk("ptr_after_rst", 32'(ptr), 32'd0);
    rst = 1'b0;
    stop_cond;

    // fresh transaction after reset, earlier contents intact
    w0 = wr_cnt;
    wq = '{8'h99};
    write_seq(8'h40);
    chk("post_rst_wr_pulse", 32'(wr_cnt - w0), 32'd1);
    rq = '{8'h99};
    read_seq(8'h40);
    rq = '{8'h5A};
    read_seq(8'h11);
    rq = '{8'hC3};
    read_seq(8'hFF);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- Synthesizable I2C target with 24C02-style byte-addressed storage.
- Sits on the SoC's open-drain i2c_sda/i2c_scl nets in the bench, downstream of the SoC I2C master, so master traffic is ACKed and returns data.
- Samples both lines with the system clock and only ever pulls SDA low; SCL is never driven (no clock stretching).

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address.
- MEM_DEPTH, 256, number of storage bytes (power of 2, at most 256).
- PAGE_SIZE, 16, write-page size in bytes (power of 2, at most MEM_DEPTH).
- SYNC_STAGES, 2, input synchronizer depth (at least 2).

Ports:
- aclk  input  1  system clock, 100 MHz in bench.
- areset  input  1  reset, synchronous, active-high.
- scl_i  input  1  SCL pin level.
- sda_i  input  1  SDA pin level.
- sda_oe  output  1  1 = pull SDA low. Bench wrapper is: i2c_sda = sda_oe ? 0 : z.
- busy  output  1  1 from matched address until STOP or next START.
- ptr  output  8  current word pointer.
- wr_pulse  output  1  one-cycle strobe on each byte commit.

Behaviour:
- Clock/reset: one clock, aclk; reset is synchronous and active-high (areset).
- Reset values: sda_oe=0, busy=0, ptr=0, wr_pulse=0, FSM=IDLE, synchronizers loaded to 1.
- Memory is not cleared by reset; it is 8'hFF at time zero.

Line sampling:
- scl_i/sda_i pass SYNC_STAGES flops, then one history flop.
- Events: scl_rise, scl_fall. START = SDA 1->0 while SCL=1. STOP = SDA 0->1 while SCL=1.
- START/STOP take priority over bit events in the same cycle.
- Data bits are sampled on scl_rise.
- sda_oe changes only on the cycle after scl_fall (pin-to-sda_oe latency SYNC_STAGES+2 aclk). The master must allow at least 5 aclk SDA hold.

FSM states: IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- Bit counter 0..7 and shift register are cleared on every START.
- START from any state -> DEV. A repeated START keeps ptr.
- STOP from any state -> IDLE; sda_oe=0 and busy=0 next cycle.
- DEV, after 8 bits:
  - address match, R/W=0 -> DEV_ACK, then WADDR.
  - address match, R/W=1 -> DEV_ACK, then RDATA.
  - mismatch -> IGNORE, no ACK.
- ACK drive: sda_oe=1 from the fall after bit 8, released at the next fall.
- WADDR: 8 bits load ptr (modulo MEM_DEPTH) -> WADDR_ACK -> WDATA.
- WDATA: after 8 bits the byte is written at ptr and wr_pulse=1 for one cycle. ptr low log2(PAGE_SIZE) bits increment with wrap; upper bits are unchanged. Then WDATA_ACK -> WDATA.
- RDATA:
  - Byte mem[ptr] is loaded at entry; MSB is driven first: sda_oe = ~bit at each scl_fall.
  - After 8 bits, SDA is released, ptr increments modulo MEM_DEPTH, state -> RACK.
  - RACK samples the master bit on scl_rise: 0 -> RDATA (next byte), 1 (NACK) -> IGNORE.
- IGNORE: sda_oe=0; waits for START/STOP.
- Reset mid-transfer: all state returns to reset values the next cycle; memory is retained.

Decomposition:
- Package i2c_pkg:
  - state enum i2c_slv_state_e.
  - constants I2C_RW_READ=1 and I2C_RW_WRITE=0.
  - ACK=0 and NACK=1.
- Sub-module i2c_line_sync: synchronizer plus history flop; outputs scl/sda levels, scl_rise, scl_fall, start_det, stop_det.
- Memory is an inferred array inside the top.

Test Plan:
- Write 0x50/W, waddr 0x10, data A5,5A, STOP -> ACK on all 4 bytes; mem[0x10]=A5, mem[0x11]=5A; two wr_pulse; busy returns 0 after STOP.
- Random read: 0x50/W, waddr 0x10, repeated START, 0x50/R, read 2 bytes (ACK then NACK), STOP -> returns A5, 5A; ptr=0x12; sda_oe released after NACK.
- Page wrap: waddr 0x1E, write 11,22,33 -> mem[1E]=11, mem[1F]=22, mem[10]=33; mem[20] stays FF.
- Address mismatch: 0x51/W then 2 bytes -> sda_oe never asserted; memory unchanged; busy=0.
- Read wrap: ptr=0xFF, read 2 bytes -> mem[FF] then mem[00]; ptr=0x01.
- areset pulsed mid-byte during a read, then STOP and a fresh write -> sda_oe=0 the cycle after reset; next transaction ACKs normally; earlier memory contents intact.
